// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, in-order imem request/response, prefetch FIFO toward decode.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect targets raise fetch_misaligned and block fetch.
//
// state | meaning
// RUN   | normal fetch, responses are pushed into the prefetch FIFO
// DRAIN | responses issued before a redirect are discarded until drop_cnt hits 0
module if_fetch_stage #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  typedef enum logic {S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic   drop_active;

  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_aligned;
  logic [CW-1:0]   outstanding, outstanding_d;
  logic [CW-1:0]   drop_cnt, drop_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [31:0]     instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic            req_fire, push, pop, fetch_block;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};

  assign imem_req_valid = !rst && !redirect_valid && !fetch_block &&
                          (credit_used < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response landing in a redirect cycle belongs to the old stream and is dropped too.
  assign push = !rst && imem_rsp_valid && !drop_active && !redirect_valid;
  assign pop  = instr_valid && !stall && !redirect_valid;

  always_comb begin
    outstanding_d = outstanding;
    if (req_fire && !imem_rsp_valid)
      outstanding_d = outstanding + CNT_ONE;
    else if (!req_fire && imem_rsp_valid)
      outstanding_d = outstanding - CNT_ONE;
  end

  always_comb begin
    drop_d = drop_cnt;
    if (redirect_valid)
      drop_d = imem_rsp_valid ? (outstanding - CNT_ONE) : outstanding;
    else if (drop_active && imem_rsp_valid)
      drop_d = drop_cnt - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
    else if (state_q == S_DRAIN && drop_d == '0)
      state_d = S_RUN;
  end

  always_comb begin
    drop_active = (state_q == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_d;
      drop_cnt    <= drop_d;
      if (redirect_valid) begin
        fetch_pc   <= redirect_aligned;
        rsp_pc     <= redirect_aligned;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + FOUR;
        if (push) begin
          rsp_pc <= rsp_pc + FOUR;
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)
          fifo_count <= fifo_count + CNT_ONE;
        else if (!push && pop)
          fifo_count <= fifo_count - CNT_ONE;
      end
      if (push && !pop) assert (fifo_count < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instruction = instr_valid ? instr_mem[rd_ptr] : NOP;
  assign pc          = instr_valid ? pc_mem[rd_ptr] : '0;
  assign pc_plus4    = pc + FOUR;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned_q;

  // Sticky until the next redirect; an aligned redirect clears it.
  always_ff @(posedge clk) begin
    if (rst)                 misaligned_q <= 1'b0;
    else if (redirect_valid) misaligned_q <= |redirect_pc[1:0];
  end

  assign fetch_misaligned = misaligned_q;
  assign fetch_block      = misaligned_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign fetch_block   = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order variable-latency memory model.
// Build with IF_MISALIGN_CHECK_EN to cover the misaligned-redirect feature.
module tb_if_fetch_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b1;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
`ifdef IF_MISALIGN_CHECK_EN
  logic            fetch_misaligned;
`endif

  if_fetch_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instruction(instruction),
    .pc(pc), .pc_plus4(pc_plus4)
`ifdef IF_MISALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rsp_t;

  rsp_t        mq[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic [31:0] got_p4[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          total = 0;
  int          bad = 0;

  // addi x1,x0,5 at 0, addi x2,x0,10 at 4, ... one distinct word per address
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0050_0093 + (a >> 2) * 32'h0050_0080;
  endfunction

  task automatic tick();
    logic        hs;
    logic [31:0] a;
    rsp_t        e;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (!rst && instr_valid && !stall && !redirect_valid) begin
      got_pc.push_back(pc);
      got_ins.push_back(instruction);
      got_p4.push_back(pc_plus4);
    end
    if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
    if (hs) begin
      e.due  = cyc + mem_lat;
      e.addr = a;
      mq.push_back(e);
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; mem_lat = 1;
    tick(); tick();
    mq.delete(); imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    got_pc.delete(); got_ins.delete(); got_p4.delete();
    rst = 1'b0;
  endtask

  task automatic run_pops(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (got_pc.size() >= n);
  endtask

  task automatic test_latency();
    bit ok;
    do_reset();
    tick(); tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL lat_early: instr_valid=%b want 0", instr_valid); end
    tick();
    total++; if ({instr_valid, pc} !== {1'b1, 32'h0}) begin bad++; $display("FAIL lat_first: valid=%b pc=%h want 1/00000000", instr_valid, pc); end
    total++; if (instruction !== 32'h0050_0093) begin bad++; $display("FAIL lat_ins0: got %h want 00500093", instruction); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL lat_p4: got %h want 00000004", pc_plus4); end
    tick();
    total++; if ({instr_valid, pc, instruction} !== {1'b1, 32'h4, 32'h00A0_0113}) begin bad++; $display("FAIL lat_second: valid=%b pc=%h ins=%h want 1/4/00a00113", instr_valid, pc, instruction); end
    run_pops(4, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL lat_timeout: pops=%0d want 4", got_pc.size()); end
    else begin
      total++; if ({got_pc[2], got_pc[3]} !== {32'h8, 32'hC}) begin bad++; $display("FAIL lat_seq: got %h %h want 8 c", got_pc[2], got_pc[3]); end
      total++; if (got_ins[3] !== word(32'hC)) begin bad++; $display("FAIL lat_ins3: got %h want %h", got_ins[3], word(32'hC)); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    total++; if (instruction !== 32'h0000_0013) begin bad++; $display("FAIL rst_ins: got %h want 00000013", instruction); end
    total++; if ({pc, pc_plus4} !== {32'h0, 32'h4}) begin bad++; $display("FAIL rst_pc: pc=%h p4=%h want 0/4", pc, pc_plus4); end
`ifdef IF_MISALIGN_CHECK_EN
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL rst_mis: got %b want 0", fetch_misaligned); end
`endif
    mq.delete(); imem_rsp_valid = 1'b0;
    got_pc.delete(); got_ins.delete(); got_p4.delete();
    rst = 1'b0;
    #1;
    total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rst_first_req: valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    tick(); tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({instr_valid, pc, instruction} !== {1'b1, 32'h4, word(32'h4)}) begin bad++; $display("FAIL stall_hold%0d: valid=%b pc=%h ins=%h want pc 4", i, instr_valid, pc, instruction); end
    end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_credit: req_valid=%b want 0", imem_req_valid); end
    got_pc.delete(); got_ins.delete(); got_p4.delete();
    stall = 1'b0;
    run_pops(4, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: pops=%0d want 4", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_pc[1], got_pc[2], got_pc[3]} !== {32'h4, 32'h8, 32'hC, 32'h10})
        begin bad++; $display("FAIL stall_seq: got %h %h %h %h want 4 8 c 10", got_pc[0], got_pc[1], got_pc[2], got_pc[3]); end
      total++; if (got_ins[2] !== word(32'hC)) begin bad++; $display("FAIL stall_ins: got %h want %h", got_ins[2], word(32'hC)); end
    end
  endtask

  task automatic test_redirect_drain();
    bit ok;
    do_reset();
    mem_lat = 3;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL drain_req_in_redirect: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    run_pops(2, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL drain_timeout: pops=%0d want 2", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_ins[0]} !== {32'h100, word(32'h100)}) begin bad++; $display("FAIL drain_first: pc=%h ins=%h want 100/%h", got_pc[0], got_ins[0], word(32'h100)); end
      total++; if ({got_pc[1], got_ins[1]} !== {32'h104, word(32'h104)}) begin bad++; $display("FAIL drain_second: pc=%h ins=%h want 104/%h", got_pc[1], got_ins[1], word(32'h104)); end
    end
  endtask

  task automatic test_redirect_stall();
    bit ok;
    do_reset();
    tick(); tick(); tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rs_flush: instr_valid=%b want 0", instr_valid); end
    total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin bad++; $display("FAIL rs_req: valid=%b addr=%h want 1/200", imem_req_valid, imem_req_addr); end
    run_pops(2, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL rs_timeout: pops=%0d want 2", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_pc[1], got_ins[0]} !== {32'h200, 32'h204, word(32'h200)})
        begin bad++; $display("FAIL rs_seq: got %h %h ins %h want 200 204 %h", got_pc[0], got_pc[1], got_ins[0], word(32'h200)); end
    end
  endtask

  task automatic test_ready_low();
    bit ok;
    int k;
    do_reset();
    tick(); tick();
    imem_req_ready = 1'b0;
    k = 0;
    while (!imem_req_valid && k < 10) begin tick(); k++; end
    for (int i = 0; i < 4; i++) begin
      total++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8}) begin bad++; $display("FAIL rdy_hold%0d: valid=%b addr=%h want 1/8", i, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    run_pops(4, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL rdy_timeout: pops=%0d want 4", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_pc[1], got_pc[2], got_pc[3]} !== {32'h0, 32'h4, 32'h8, 32'hC})
        begin bad++; $display("FAIL rdy_seq: got %h %h %h %h want 0 4 8 c", got_pc[0], got_pc[1], got_pc[2], got_pc[3]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    run_pops(2, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: pops=%0d want 2", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_pc[1]} !== {32'hFFFF_FFFC, 32'h0}) begin bad++; $display("FAIL wrap_seq: got %h %h want fffffffc 0", got_pc[0], got_pc[1]); end
      total++; if (got_p4[0] !== 32'h0) begin bad++; $display("FAIL wrap_p4: got %h want 0", got_p4[0]); end
      total++; if (got_ins[0] !== word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_ins: got %h want %h", got_ins[0], word(32'hFFFF_FFFC)); end
    end
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    logic any_req;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", fetch_misaligned); end
    any_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_req = any_req | imem_req_valid;
      tick();
    end
    total++; if ({any_req, instr_valid} !== 2'b00) begin bad++; $display("FAIL mis_block: req_seen=%b valid=%b want 0/0", any_req, instr_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++; if ({fetch_misaligned, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h100})
      begin bad++; $display("FAIL mis_clear: flag=%b valid=%b addr=%h want 0/1/100", fetch_misaligned, imem_req_valid, imem_req_addr); end
  endtask
`else
  task automatic test_misalign();
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    run_pops(1, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL mis_timeout: pops=%0d want 1", got_pc.size()); end
    else begin
      total++; if ({got_pc[0], got_ins[0]} !== {32'h100, word(32'h100)}) begin bad++; $display("FAIL mis_clear_lsb: pc=%h ins=%h want 100/%h", got_pc[0], got_ins[0], word(32'h100)); end
    end
  endtask
`endif

  initial begin
    do_reset();
    test_latency();
    test_reset();
    test_stall();
    test_redirect_drain();
    test_redirect_stall();
    test_ready_low();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
